// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mdu_pkg                                                   |
// | Brief    : Shared constants for the RV32M multiply/divide unit:      |
// |            funct3 op codes, FSM state encodings, divider length.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mdu_pkg;

  // funct3 encodings of the M-extension ops
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // One quotient bit per cycle over a 32-bit dividend
  localparam int MDU_DIV_CYCLES = 32;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_MUL  = 3'd1;
  localparam state_t S_SPEC = 3'd2;
  localparam state_t S_DIV  = 3'd3;
  localparam state_t S_FIX  = 3'd4;
  localparam state_t S_DONE = 3'd5;

  // Any divide/remainder op
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Divide/remainder ops that treat operands as two's complement
  function automatic logic is_signed_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Ops that return the remainder rather than the quotient
  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mdu_if                                                    |
// | Brief    : ID/EX -> MDU request bundle and MDU -> write-back results.|
// |            master = pipeline side, slave = MDU side.                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface mdu_if #(
  parameter int XLEN     = 32,
  parameter int REG_SIZE = 5
);
  logic                flush_from_flushunit;
  logic                mdu_start_from_idex;
  logic [2:0]          mdu_op_from_idex;
  logic [XLEN-1:0]     rs1_from_idex;
  logic [XLEN-1:0]     rs2_from_idex;
  logic [REG_SIZE-1:0] rd_from_idex;
  logic [REG_SIZE-1:0] mdu_now_rd_to_wb;
  logic                mdu_busy_to_wb;
  logic                mdu_finish_to_wb;
  logic [XLEN-1:0]     mdu_result_to_wb;

  modport master (
    output flush_from_flushunit, mdu_start_from_idex, mdu_op_from_idex,
           rs1_from_idex, rs2_from_idex, rd_from_idex,
    input  mdu_now_rd_to_wb, mdu_busy_to_wb, mdu_finish_to_wb, mdu_result_to_wb
  );

  modport slave (
    input  flush_from_flushunit, mdu_start_from_idex, mdu_op_from_idex,
           rs1_from_idex, rs2_from_idex, rd_from_idex,
    output mdu_now_rd_to_wb, mdu_busy_to_wb, mdu_finish_to_wb, mdu_result_to_wb
  );
endinterface
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mdu_div_core                                              |
// | Brief    : Unsigned radix-2 restoring divider, one quotient bit per  |
// |            cycle for MDU_DIV_CYCLES cycles after a start pulse.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            i_start,
  input  wire logic [XLEN-1:0] i_dividend,
  input  wire logic [XLEN-1:0] i_divisor,
  output logic      [XLEN-1:0] o_quotient,
  output logic      [XLEN-1:0] o_remainder,
  // High during the final iteration; quotient/remainder are valid next cycle
  output logic                 o_done
);

  localparam int CNT_W = $clog2(MDU_DIV_CYCLES);

  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [XLEN:0]    w_rem_sh;
  logic             w_ge;
  logic [XLEN-1:0]  w_sub;
  logic             w_last;

  // Shift the next dividend bit into the partial remainder and trial-subtract
  always_comb begin
    w_rem_sh = {r_rem, r_quo[XLEN-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_div});
    // The true difference is below the divisor, so the low bits are exact
    w_sub    = w_rem_sh[XLEN-1:0] - r_div;
    w_last   = r_busy && (r_cnt == CNT_W'(MDU_DIV_CYCLES - 1));
  end

  // Iteration registers: load on start, then one restoring step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_ge ? w_sub : w_rem_sh[XLEN-1:0];
      r_quo  <= {r_quo[XLEN-2:0], w_ge};
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_done      = w_last;

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mdu_unit                                                  |
// | Brief    : Iterative RV32M multiply/divide unit. Multiplies in 2     |
// |            cycles, divides in 34 (2 for divide-by-zero/overflow).    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_SIZE = 5
) (
  input wire logic clk,
  input wire logic rst,
  mdu_if.slave     bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [REG_SIZE-1:0] r_rd;
  logic [XLEN-1:0]     r_result;

  logic                w_accept;
  logic                w_in_div;
  logic                w_in_signed;
  logic                w_in_special;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_div_start;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic                w_div_done;

  logic                w_sa;
  logic                w_sb;
  logic [2*XLEN-1:0]   w_a_ext;
  logic [2*XLEN-1:0]   w_b_ext;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_mul_res;
  logic [XLEN-1:0]     w_spec_res;
  logic [XLEN-1:0]     w_fix_res;
  logic                w_neg_q;
  logic                w_neg_r;
  logic                w_busy;
  logic                w_finish;

  // Request decode: acceptance, special-case detection, operand magnitudes
  always_comb begin
    w_accept     = bus.mdu_start_from_idex && !bus.flush_from_flushunit &&
                   ((r_state == S_IDLE) || (r_state == S_DONE));
    w_in_div     = is_div_op(bus.mdu_op_from_idex);
    w_in_signed  = is_signed_div(bus.mdu_op_from_idex);
    w_in_special = (bus.rs2_from_idex == '0) ||
                   (w_in_signed &&
                    (bus.rs1_from_idex == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (bus.rs2_from_idex == '1));
    w_abs_a      = (w_in_signed && bus.rs1_from_idex[XLEN-1]) ? -bus.rs1_from_idex
                                                               : bus.rs1_from_idex;
    w_abs_b      = (w_in_signed && bus.rs2_from_idex[XLEN-1]) ? -bus.rs2_from_idex
                                                               : bus.rs2_from_idex;
    w_div_start  = w_accept && w_in_div && !w_in_special;
  end

  mdu_div_core #(
    .XLEN (XLEN)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_done      (w_div_done)
  );

  // Result formation for each completing path
  always_comb begin
    // 33-bit signed operands sign-extended to 64 bits; the low 64 product bits are exact
    w_sa    = ((r_op == OP_MULH) || (r_op == OP_MULHSU)) && r_a[XLEN-1];
    w_sb    = (r_op == OP_MULH) && r_b[XLEN-1];
    w_a_ext = {{XLEN{w_sa}}, r_a};
    w_b_ext = {{XLEN{w_sb}}, r_b};
    w_prod  = w_a_ext * w_b_ext;
    case (r_op)
      OP_MULH, OP_MULHSU, OP_MULHU: w_mul_res = w_prod[2*XLEN-1:XLEN];
      default:                      w_mul_res = w_prod[XLEN-1:0];
    endcase

    if (r_b == '0) begin
      w_spec_res = is_rem_op(r_op) ? r_a : '1;
    end else begin
      w_spec_res = is_rem_op(r_op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Quotient sign is the XOR of operand signs; remainder follows the dividend
    w_neg_q   = is_signed_div(r_op) && (r_a[XLEN-1] ^ r_b[XLEN-1]);
    w_neg_r   = is_signed_div(r_op) && r_a[XLEN-1];
    if (is_rem_op(r_op)) begin
      w_fix_res = w_neg_r ? -w_rem : w_rem;
    end else begin
      w_fix_res = w_neg_q ? -w_quo : w_quo;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (!w_in_div)        w_state_nxt = S_MUL;
          else if (w_in_special) w_state_nxt = S_SPEC;
          else                  w_state_nxt = S_DIV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL:   w_state_nxt = S_DONE;
      S_SPEC:  w_state_nxt = S_DONE;
      S_DIV:   w_state_nxt = w_div_done ? S_FIX : S_DIV;
      S_FIX:   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy   = (r_state == S_MUL) || (r_state == S_SPEC) ||
               (r_state == S_DIV) || (r_state == S_FIX);
    w_finish = (r_state == S_DONE);
  end

  // Operand capture on accept; result register loads on the cycle before DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rd     <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op <= bus.mdu_op_from_idex;
        r_a  <= bus.rs1_from_idex;
        r_b  <= bus.rs2_from_idex;
        r_rd <= bus.rd_from_idex;
      end
      case (r_state)
        S_MUL:   r_result <= w_mul_res;
        S_SPEC:  r_result <= w_spec_res;
        S_FIX:   r_result <= w_fix_res;
        default: r_result <= r_result;
      endcase
    end
  end

  assign bus.mdu_now_rd_to_wb = r_rd;
  assign bus.mdu_busy_to_wb   = w_busy;
  assign bus.mdu_finish_to_wb = w_finish;
  assign bus.mdu_result_to_wb = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mdu_unit                                               |
// | Brief    : Scoreboard bench for mdu_unit: directed RV32M cases plus  |
// |            random ops against an arithmetic reference model.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mdu_unit;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  mdu_if #(.XLEN(32), .REG_SIZE(5)) bus ();

  mdu_unit #(.XLEN(32), .REG_SIZE(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle index; stimulus driven at posedge+1 sees the index of that cycle
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference result computed directly from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    r  = 32'd0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else r = ia / ib;
      end
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else r = ia % ib;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every finish pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.mdu_finish_to_wb) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_finish: rd=%0d result=%h at cycle %0d",
                 bus.mdu_now_rd_to_wb, bus.mdu_result_to_wb, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_result", bus.mdu_result_to_wb, e.res);
        chk("wb_rd", 32'(bus.mdu_now_rd_to_wb), 32'(e.rd));
        chk("wb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  int last_rd = 0;

  // Issue one op and walk it to completion, checking busy/now_rd along the way.
  // intrude_at: cycle offset at which an illegal start (rd=9) is presented.
  // rst_at: cycle offset at which reset is pulsed, abandoning the op.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int intrude_at, input int rst_at);
    int          lat;
    logic [31:0] res;
    exp_t        e;
    res = model(op, a, b);
    lat = ref_latency(op, a, b);
    @(posedge clk); #1;
    bus.mdu_start_from_idex = 1'b1;
    bus.mdu_op_from_idex    = op;
    bus.rs1_from_idex       = a;
    bus.rs2_from_idex       = b;
    bus.rd_from_idex        = rd;
    e.rd = rd; e.res = res; e.cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.mdu_start_from_idex = 1'b0;
    last_rd = int'(rd);
    for (int i = 1; i < lat; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", 32'(bus.mdu_busy_to_wb), 32'd0);
        chk("rst_finish", 32'(bus.mdu_finish_to_wb), 32'd0);
        chk("rst_result", bus.mdu_result_to_wb, 32'd0);
        chk("rst_now_rd", 32'(bus.mdu_now_rd_to_wb), 32'd0);
        last_rd = 0;
        repeat (40) @(posedge clk);
        #1;
        chk("rst_still_idle", 32'(bus.mdu_busy_to_wb), 32'd0);
        return;
      end
      chk("busy_in_flight", 32'(bus.mdu_busy_to_wb), 32'd1);
      chk("now_rd_in_flight", 32'(bus.mdu_now_rd_to_wb), 32'(rd));
      if (i == intrude_at) begin
        bus.mdu_start_from_idex = 1'b1;
        bus.mdu_op_from_idex    = 3'd0;
        bus.rs1_from_idex       = 32'd3;
        bus.rs2_from_idex       = 32'd5;
        bus.rd_from_idex        = 5'd9;
      end else begin
        bus.mdu_start_from_idex = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.mdu_start_from_idex = 1'b0;
    chk("busy_at_done", 32'(bus.mdu_busy_to_wb), 32'd0);
    @(posedge clk); #1;
    chk("result_hold", bus.mdu_result_to_wb, res);
    chk("finish_one_cycle", 32'(bus.mdu_finish_to_wb), 32'd0);
    chk("busy_idle", 32'(bus.mdu_busy_to_wb), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bus.flush_from_flushunit = 1'b0;
    bus.mdu_start_from_idex  = 1'b0;
    bus.mdu_op_from_idex     = 3'd0;
    bus.rs1_from_idex        = 32'd0;
    bus.rs2_from_idex        = 32'd0;
    bus.rd_from_idex         = 5'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.mdu_busy_to_wb), 32'd0);
    chk("reset_finish", 32'(bus.mdu_finish_to_wb), 32'd0);
    chk("reset_result", bus.mdu_result_to_wb, 32'd0);
    chk("reset_now_rd", 32'(bus.mdu_now_rd_to_wb), 32'd0);
    rst = 1'b0;

    // Multiplies
    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 5'd1, 0, 0);
    run_op(3'd1, 32'h80000000, 32'h80000000, 5'd2, 0, 0);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 0, 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 0, 0);
    // Full-length divides
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        5'd5, 0, 0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        5'd6, 0, 0);
    run_op(3'd5, 32'd100,      32'd7,        5'd7, 0, 0);
    run_op(3'd7, 32'd100,      32'd7,        5'd8, 0, 0);
    // Short-path special cases
    run_op(3'd4, 32'd5,        32'd0,        5'd10, 0, 0);
    run_op(3'd7, 32'd5,        32'd0,        5'd11, 0, 0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 0, 0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 0, 0);
    // rd=0 still completes normally
    run_op(3'd0, 32'd6,        32'd7,        5'd0, 0, 0);

    // Start with flush is dropped
    @(posedge clk); #1;
    bus.mdu_start_from_idex  = 1'b1;
    bus.flush_from_flushunit = 1'b1;
    bus.mdu_op_from_idex     = 3'd4;
    bus.rs1_from_idex        = 32'd50;
    bus.rs2_from_idex        = 32'd5;
    bus.rd_from_idex         = 5'd17;
    @(posedge clk); #1;
    bus.mdu_start_from_idex  = 1'b0;
    bus.flush_from_flushunit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_busy", 32'(bus.mdu_busy_to_wb), 32'd0);
      chk("flush_now_rd", 32'(bus.mdu_now_rd_to_wb), 32'(last_rd));
      @(posedge clk); #1;
    end

    // Start while a divide is in flight is ignored
    run_op(3'd4, 32'd1000, 32'd3, 5'd3, 5, 0);

    // Back-to-back: second MUL accepted in the first op's DONE cycle
    @(posedge clk); #1;
    bus.mdu_start_from_idex = 1'b1;
    bus.mdu_op_from_idex    = 3'd0;
    bus.rs1_from_idex       = 32'd11;
    bus.rs2_from_idex       = 32'd13;
    bus.rd_from_idex        = 5'd20;
    e.rd = 5'd20; e.res = model(3'd0, 32'd11, 32'd13); e.cyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.mdu_start_from_idex = 1'b0;
    @(posedge clk); #1;
    bus.mdu_start_from_idex = 1'b1;
    bus.mdu_op_from_idex    = 3'd3;
    bus.rs1_from_idex       = 32'hDEADBEEF;
    bus.rs2_from_idex       = 32'h12345678;
    bus.rd_from_idex        = 5'd21;
    e.rd = 5'd21; e.res = model(3'd3, 32'hDEADBEEF, 32'h12345678); e.cyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.mdu_start_from_idex = 1'b0;
    chk("b2b_busy", 32'(bus.mdu_busy_to_wb), 32'd1);
    chk("b2b_now_rd", 32'(bus.mdu_now_rd_to_wb), 32'd21);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_idle", 32'(bus.mdu_busy_to_wb), 32'd0);

    // Reset in the middle of a divide abandons it
    run_op(3'd5, 32'd12345, 32'd17, 5'd6, 0, 10);

    // Random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = rnd_operand();
      b  = rnd_operand();
      run_op(op, a, b, 5'($urandom_range(0, 31)), 0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
